// File: rtl/mig_pkg.sv
// rtl/mig_pkg.sv - shared command codes, controller states and defaults for the MIG burst controller
package mig_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int ADDR_STEP_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/mig_beat_cnt.sv
// rtl/mig_beat_cnt.sv - beat counter with clear, increment and terminal-beat flag
module mig_beat_cnt #(
  parameter int LEN_W = 16
) (
  input  logic             ui_clk,
  input  logic             ui_rstn,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] count,
  output logic             last
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

  // Flags the increment that consumes the final beat of the burst.
  assign last = inc && (count == (len - ONE));

endmodule

// File: rtl/mig_burst_ctrl.sv
// rtl/mig_burst_ctrl.sv - burst-level write/read requests to MIG 7-series native app-interface commands
module mig_burst_ctrl
  import mig_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic                ui_clk,
  input  logic                ui_rstn,
  input  logic                init_calib_complete,

  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [LEN_W-1:0]    wr_length,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_busy,
  output logic                wr_data_valid,
  output logic                wr_done,

  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_req_addr,
  input  logic [LEN_W-1:0]    rd_length,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_busy,
  output logic                rd_data_valid,
  output logic                rd_done,

  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t           state, state_nxt;
  logic             busy_q;
  logic             wr_done_q, rd_done_q;
  logic             wr_done_nxt, rd_done_nxt;
  logic             accept_wr, accept_rd;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cmd_cnt, dat_cnt;
  logic             cmd_inc, dat_inc, cmd_last, dat_last;
  logic             beat_go, rd_phase;

  assign beat_go  = app_rdy & app_wdf_rdy;
  assign rd_phase = (state == RD) || (state == RD_WAIT);

  // Command/beat strobes are kept outside the FSM block so the terminal
  // flags fed back from the counters never form a combinational loop.
  assign cmd_inc = ((state == WR) && beat_go) ||
                   ((state == RD) && app_rdy && (cmd_cnt < len_q));
  assign dat_inc = rd_phase && app_rd_data_valid && (dat_cnt < len_q);

  assign app_en        = cmd_inc;
  assign app_wdf_wren  = (state == WR) && beat_go;
  assign app_wdf_end   = app_wdf_wren;
  assign app_wdf_data  = wr_data;
  assign app_wdf_mask  = '0;
  assign wr_data_valid = app_wdf_wren;

  assign rd_data       = app_rd_data;
  assign rd_data_valid = rd_phase && app_rd_data_valid;

  assign wr_busy = busy_q;
  assign rd_busy = busy_q;
  assign wr_done = wr_done_q;
  assign rd_done = rd_done_q;

  always_comb begin
    state_nxt   = state;
    accept_wr   = 1'b0;
    accept_rd   = 1'b0;
    wr_done_nxt = 1'b0;
    rd_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        // Zero-length requests complete immediately without touching the MIG.
        if (init_calib_complete) begin
          if (wr_req) begin
            if (wr_length != '0) begin
              accept_wr = 1'b1;
              state_nxt = WR;
            end else begin
              wr_done_nxt = 1'b1;
            end
          end else if (rd_req) begin
            if (rd_length != '0) begin
              accept_rd = 1'b1;
              state_nxt = RD;
            end else begin
              rd_done_nxt = 1'b1;
            end
          end
        end
      end
      WR: begin
        if (cmd_last) begin
          state_nxt   = IDLE;
          wr_done_nxt = 1'b1;
        end
      end
      RD: begin
        if (dat_last) begin
          state_nxt   = IDLE;
          rd_done_nxt = 1'b1;
        end else if (cmd_last) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (dat_last) begin
          state_nxt   = IDLE;
          rd_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      app_addr  <= '0;
      app_cmd   <= CMD_WR;
      len_q     <= '0;
    end else begin
      state     <= state_nxt;
      busy_q    <= (state_nxt != IDLE);
      wr_done_q <= wr_done_nxt;
      rd_done_q <= rd_done_nxt;
      if (accept_wr) begin
        app_addr <= wr_req_addr;
        len_q    <= wr_length;
        app_cmd  <= CMD_WR;
      end else if (accept_rd) begin
        app_addr <= rd_req_addr;
        len_q    <= rd_length;
        app_cmd  <= CMD_RD;
      end else if (cmd_inc) begin
        app_addr <= app_addr + STEP;
      end
    end
  end

  mig_beat_cnt #(.LEN_W(LEN_W)) u_cmd_cnt (
    .ui_clk  (ui_clk),
    .ui_rstn (ui_rstn),
    .clr     (accept_wr | accept_rd),
    .inc     (cmd_inc),
    .len     (len_q),
    .count   (cmd_cnt),
    .last    (cmd_last)
  );

  mig_beat_cnt #(.LEN_W(LEN_W)) u_dat_cnt (
    .ui_clk  (ui_clk),
    .ui_rstn (ui_rstn),
    .clr     (accept_wr | accept_rd),
    .inc     (dat_inc),
    .len     (len_q),
    .count   (dat_cnt),
    .last    (dat_last)
  );

endmodule
